// File: rtl/a51_keystream_ctrl_if.sv
// Keystream request/response bundle between the A5/1 controller and its user.
// The slave side is the controller; the master side drives start/key/frame and accepts bits.
interface a51_keystream_ctrl_if;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        busy;
  logic        ks_valid;
  logic        ks_ready;
  logic        ks_bit;
  logic        done;

  modport master (output start, key, frame, ks_ready,
                  input  busy, ks_valid, ks_bit, done);
  modport slave  (input  start, key, frame, ks_ready,
                  output busy, ks_valid, ks_bit, done);
endinterface

// File: rtl/a51_keystream_ctrl.sv
// A5/1 keystream sequencer: key/frame load, 101 majority-clocked mix steps,
// then 228 output bits over a valid/ready handshake.
module a51_keystream_ctrl (
  input  logic                  clk,
  input  logic                  reset_n,
  a51_keystream_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, KEY, FRAME, MIX, OUT, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [18:0] r1;
  logic [21:0] r2;
  logic [22:0] r3;
  logic [63:0] key_q;
  logic [21:0] frame_q;
  logic        busy_q, valid_q, done_q;

  logic fb1, fb2, fb3, maj, load, inj, step;
  logic en1, en2, en3;

  assign fb1  = r1[13] ^ r1[16] ^ r1[17] ^ r1[18];
  assign fb2  = r2[20] ^ r2[21];
  assign fb3  = r3[7] ^ r3[20] ^ r3[21] ^ r3[22];
  assign maj  = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
  assign load = (state == KEY) || (state == FRAME);
  assign inj  = (state == KEY) ? key_q[0] : ((state == FRAME) ? frame_q[0] : 1'b0);

  // The last accepted bit leaves the registers untouched so the final state is the 228th output.
  assign step = load || (state == MIX) ||
                ((state == OUT) && bus.ks_ready && (cnt != 8'd227));
  assign en1  = load || (r1[8]  == maj);
  assign en2  = load || (r2[10] == maj);
  assign en3  = load || (r3[10] == maj);

  assign bus.busy     = busy_q;
  assign bus.ks_valid = valid_q;
  assign bus.done     = done_q;
  assign bus.ks_bit   = r1[18] ^ r2[21] ^ r3[22];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      r1      <= '0;
      r2      <= '0;
      r3      <= '0;
      key_q   <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (step) begin
        if (en1) r1 <= {r1[17:0], fb1 ^ inj};
        if (en2) r2 <= {r2[20:0], fb2 ^ inj};
        if (en3) r3 <= {r3[21:0], fb3 ^ inj};
      end
      case (state)
        IDLE: if (bus.start) begin
          r1      <= '0;
          r2      <= '0;
          r3      <= '0;
          key_q   <= bus.key;
          frame_q <= bus.frame;
          cnt     <= '0;
          busy_q  <= 1'b1;
          state   <= KEY;
        end
        KEY: begin
          key_q <= key_q >> 1;
          if (cnt == 8'd63) begin
            cnt   <= '0;
            state <= FRAME;
          end else cnt <= cnt + 8'd1;
        end
        FRAME: begin
          frame_q <= frame_q >> 1;
          if (cnt == 8'd21) begin
            cnt   <= '0;
            state <= MIX;
          end else cnt <= cnt + 8'd1;
        end
        MIX: begin
          if (cnt == 8'd100) begin
            cnt     <= '0;
            valid_q <= 1'b1;
            state   <= OUT;
          end else cnt <= cnt + 8'd1;
        end
        OUT: if (bus.ks_ready) begin
          if (cnt == 8'd227) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end else cnt <= cnt + 8'd1;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// Bench for a51_keystream_ctrl: reference vector, back-pressure, ignored start,
// mid-run reset, back-to-back and random keys against a software A5/1 model.
module tb_a51_keystream_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  a51_keystream_ctrl_if bus();
  a51_keystream_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  localparam logic [63:0]  REF_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0]  REF_FRAME = 22'h000134;
  localparam logic [119:0] REF_DL    = 120'h534EAA582FE8151AB6E1855A728C00;
  localparam logic [119:0] REF_UL    = 120'h24FD35A35D5FB6526D32F906DF1AC0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // State packed as {R1[18:0], R2[21:0], R3[22:0]}; taps given as masks.
  function automatic logic [63:0] lfsr_all(logic [63:0] s, logic inb);
    logic [18:0] a; logic [21:0] b; logic [22:0] c;
    {a, b, c} = s;
    a = {a[17:0], (^(a & 19'h72000)) ^ inb};
    b = {b[20:0], (^(b & 22'h300000)) ^ inb};
    c = {c[21:0], (^(c & 23'h700080)) ^ inb};
    return {a, b, c};
  endfunction

  function automatic logic [63:0] maj_step(logic [63:0] s);
    logic [18:0] a; logic [21:0] b; logic [22:0] c;
    logic [63:0] all;
    int votes;
    logic m;
    {a, b, c} = s;
    votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
    m = (votes >= 2);
    all = lfsr_all(s, 1'b0);
    if (a[8]  == m) a = all[63:45];
    if (b[10] == m) b = all[44:23];
    if (c[10] == m) c = all[22:0];
    return {a, b, c};
  endfunction

  function automatic logic [227:0] model_ks(logic [63:0] k, logic [21:0] f);
    logic [63:0] s = '0;
    logic [227:0] ks = '0;
    for (int i = 0; i < 64; i++) s = lfsr_all(s, k[i]);
    for (int i = 0; i < 22; i++) s = lfsr_all(s, f[i]);
    for (int i = 0; i < 100; i++) s = maj_step(s);
    for (int i = 0; i < 228; i++) begin
      s = maj_step(s);
      ks[i] = s[63] ^ s[44] ^ s[22];
    end
    return ks;
  endfunction

  task automatic run(input logic [63:0] k, input logic [21:0] f, input int stall,
                     input bit pokes, input bit regchk, input int abort_at,
                     output logic [227:0] got, output int nb, output int fv, output int dc);
    int cyc;
    bit prev_stall, acc, fin;
    logic prev_bit;
    logic [63:0] prev_s;
    got = '0; nb = 0; fv = -1; dc = -1; prev_stall = 0; prev_bit = 0; fin = 0;
    chk("idle_before_start", bus.busy, 0);
    bus.key = k; bus.frame = f; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.key   = {$urandom, $urandom};
    bus.frame = 22'($urandom);
    chk("busy_after_start", bus.busy, 1);
    cyc = 0;
    while (!fin && cyc < 3000) begin
      bus.ks_ready = ($urandom_range(99) >= stall);
      if (pokes) bus.start = (cyc == 10 || cyc == 150 || cyc == 300);
      if (bus.ks_valid && fv < 0) fv = cyc;
      if (prev_stall && bus.ks_valid) chk("stall_stable", bus.ks_bit, prev_bit);
      acc        = bus.ks_valid && bus.ks_ready;
      prev_stall = bus.ks_valid && !bus.ks_ready;
      prev_bit   = bus.ks_bit;
      prev_s     = {dut.r1, dut.r2, dut.r3};
      if (acc) begin
        if (nb < 228) got[nb] = bus.ks_bit;
        nb++;
      end
      if (abort_at > 0 && acc && nb == abort_at) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.ks_valid, 0);
        chk("rst_done", bus.done, 0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
      if (regchk && acc && nb < 228)
        chk("maj_step", {dut.r1, dut.r2, dut.r3}, maj_step(prev_s));
      if (bus.done) begin
        dc = cyc;
        fin = 1;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", fin, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
    chk("busy_low_after_done", bus.busy, 0);
  endtask

  initial begin
    logic [227:0] exp_ref, exp_m, got;
    logic [119:0] dl, ul;
    logic [63:0] rk;
    logic [21:0] rf;
    int nb, fv, dc;

    dl = REF_DL; ul = REF_UL;
    for (int i = 0; i < 114; i++) begin
      exp_ref[i]       = dl[119 - i];
      exp_ref[114 + i] = ul[119 - i];
    end

    reset_n = 1'b0; bus.start = 1'b0; bus.key = '0; bus.frame = '0; bus.ks_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_valid", bus.ks_valid, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_ks_bit", bus.ks_bit, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reference vector at full rate, with per-step register checks.
    run(REF_KEY, REF_FRAME, 0, 0, 1, 0, got, nb, fv, dc);
    chk("ref_stream", got, exp_ref);
    chk("ref_count", nb, 228);
    chk("ref_first_valid", fv, 187);
    chk("ref_done_cycle", dc, 415);

    // Back-to-back: started in the only idle cycle after the previous run.
    exp_m = model_ks('0, '0);
    run('0, '0, 0, 0, 1, 0, got, nb, fv, dc);
    chk("zero_stream", got, exp_m);
    chk("zero_count", nb, 228);
    chk("zero_first_valid", fv, 187);

    run(REF_KEY, REF_FRAME, 30, 0, 1, 0, got, nb, fv, dc);
    chk("stall_stream", got, exp_ref);
    chk("stall_count", nb, 228);

    run(REF_KEY, REF_FRAME, 0, 1, 0, 0, got, nb, fv, dc);
    chk("poke_stream", got, exp_ref);
    chk("poke_count", nb, 228);
    chk("poke_done_cycle", dc, 415);

    run(REF_KEY, REF_FRAME, 0, 0, 0, 51, got, nb, fv, dc);
    chk("abort_bits_before", got[50:0], exp_ref[50:0]);
    repeat (2) @(posedge clk);
    #1;
    run(REF_KEY, REF_FRAME, 0, 0, 0, 0, got, nb, fv, dc);
    chk("after_reset_stream", got, exp_ref);
    chk("after_reset_count", nb, 228);

    for (int r = 0; r < 3; r++) begin
      rk = {$urandom, $urandom};
      rf = 22'($urandom);
      exp_m = model_ks(rk, rf);
      run(rk, rf, 20, 0, 1, 0, got, nb, fv, dc);
      chk("rand_stream", got, exp_m);
      chk("rand_count", nb, 228);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
